// File: rtl/cpu_div_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_div_pkg
//  Description : Shared types and constants for the sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_div_pkg;

  localparam int DIV_WIDTH     = 32;
  localparam int DIV_CNT_WIDTH = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration on
//                unsigned magnitudes.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // Shift {rem,quo} left, trial-subtract and restore when the trial goes negative.
  // A set rem MSB means the shifted value exceeds any WIDTH-bit divisor, so the
  // trial always fits even though its sign bit looks negative (divide-by-zero).
  always_comb begin
    w_shifted = {rem, quo[WIDTH-1]};
    w_trial   = w_shifted - {1'b0, divisor};
    w_fits    = rem[WIDTH-1] | ~w_trial[WIDTH];
    rem_next  = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], w_fits};
  end

endmodule
`default_nettype wire

// File: rtl/div_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_unit
//  Description : Multi-cycle restoring divider for DIV/DIVU. Produces
//                {remainder, quotient} with a one-cycle HI/LO write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_unit
  import cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic [2*WIDTH-1:0] div_ans,
  output logic               hilo_we,
  output logic               div_by_zero
);

  localparam int CNT_WIDTH = $clog2(WIDTH + 1);

  div_state_t           r_state;
  div_state_t           w_stateNext;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;
  logic [WIDTH-1:0]     r_dividendRaw;
  logic                 r_negQuo;
  logic                 r_negRem;
  logic                 r_divZero;
  logic                 r_divByZero;
  logic [2*WIDTH-1:0]   r_divAns;

  logic [WIDTH-1:0]     w_dividendMag;
  logic [WIDTH-1:0]     w_divisorMag;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic [WIDTH-1:0]     w_remFix;
  logic [WIDTH-1:0]     w_quoFix;
  logic [2*WIDTH-1:0]   w_fixedAns;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_divisor),
    .rem_next (w_remNext),
    .quo_next (w_quoNext)
  );

  // Operand magnitudes on the way in, sign correction on the way out.
  // Divide-by-zero keeps the raw datapath result: all-ones quotient, raw dividend.
  always_comb begin
    w_dividendMag = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    w_divisorMag  = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
    w_quoFix      = r_negQuo ? -r_quo : r_quo;
    w_remFix      = r_negRem ? -r_rem : r_rem;
    w_fixedAns    = r_divZero ? {r_dividendRaw, {WIDTH{1'b1}}} : {w_remFix, w_quoFix};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state logic: IDLE -> CALC (WIDTH steps) -> FIXUP -> DONE -> IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = CALC;
      CALC:    if (r_cnt == CNT_WIDTH'(1)) w_stateNext = FIXUP;
      FIXUP:   w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Outputs decoded from state; div_ans and div_by_zero come straight from registers.
  always_comb begin
    busy        = (r_state != IDLE);
    hilo_we     = (r_state == DONE);
    div_ans     = r_divAns;
    div_by_zero = r_divByZero;
  end

  // Datapath: operand capture, one iteration per CALC cycle, result load in FIXUP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_divisor     <= '0;
      r_dividendRaw <= '0;
      r_negQuo      <= 1'b0;
      r_negRem      <= 1'b0;
      r_divZero     <= 1'b0;
      r_divByZero   <= 1'b0;
      r_divAns      <= '0;
    end else begin
      // Only high during DONE, since it is loaded solely on the FIXUP cycle.
      r_divByZero <= (r_state == FIXUP) & r_divZero;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rem         <= '0;
            r_quo         <= w_dividendMag;
            r_divisor     <= w_divisorMag;
            r_dividendRaw <= dividend;
            r_negQuo      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_negRem      <= is_signed & dividend[WIDTH-1];
            r_divZero     <= (divisor == '0);
            r_cnt         <= CNT_WIDTH'(WIDTH);
          end
        end
        CALC: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_cnt <= r_cnt - CNT_WIDTH'(1);
        end
        FIXUP:   r_divAns <= w_fixedAns;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
